// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and load-data helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_DONE
  } state_e;

  // Access size in bytes (1, 2 or 4) from funct3.
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned loads have no store counterpart; 011/110/111 are never legal.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b1;
      F3_LBU, F3_LHU:      return !we;
      default:             return 1'b0;
    endcase
  endfunction

  // Pull the addressed bytes down to bit 0 from the {hi,lo} word pair.
  function automatic logic [XLEN-1:0] load_merge(input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo,
                                                  input logic [1:0]      off);
    logic [2*XLEN-1:0] pair;
    pair = {hi, lo} >> {off, 3'b000};
    return pair[XLEN-1:0];
  endfunction

  // Sign- or zero-extend the LSB-aligned load bytes.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                   input logic [XLEN-1:0] raw);
    case (f3)
      F3_LB:   return {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LBU:  return {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LH:   return {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LHU:  return {{(XLEN-16){1'b0}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Data-memory request/grant/response bus between the LSU and memory.
interface lsu_mem_port_if;

  logic                      mem_req;
  logic                      mem_we;
  logic [lsu_pkg::XLEN-1:0]  mem_addr;
  logic [3:0]                mem_be;
  logic [lsu_pkg::XLEN-1:0]  mem_wdata;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [lsu_pkg::XLEN-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane placement for one word transaction of a possibly split access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      offset,
  input  logic [2:0]      size,
  input  logic            phase,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata
);

  logic [3:0]        mask;
  logic [7:0]        be_pair;
  logic [2*XLEN-1:0] data_pair;

  // Shift mask and data across a two-word window; phase 1 takes the spill-over half.
  always_comb begin
    case (size)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be_pair   = {4'b0000, mask} << offset;
    data_pair = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
    mem_be    = phase ? be_pair[7:4] : be_pair[3:0];
    mem_wdata = phase ? data_pair[2*XLEN-1:XLEN] : data_pair[XLEN-1:0];
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: drives the memory bus, splits misaligned accesses, stalls the pipe.
module lsu_mem_port
  import lsu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                stall,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  lsu_mem_port_if.master      bus
);

  state_e          state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] lo_q;

  logic [1:0]      al_off;
  logic [2:0]      al_size;
  logic            al_phase;
  logic [XLEN-1:0] al_wdata_in;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic            split;
  logic [XLEN-1:0] addr1;

  // In IDLE the aligner sees the incoming request (phase 0); afterwards the captured one (phase 1).
  always_comb begin
    if (state == S_IDLE) begin
      al_off      = req_addr[1:0];
      al_size     = size_of(req_funct3);
      al_phase    = 1'b0;
      al_wdata_in = req_wdata;
    end else begin
      al_off      = addr_q[1:0];
      al_size     = size_of(f3_q);
      al_phase    = 1'b1;
      al_wdata_in = wdata_q;
    end
  end

  lsu_align u_align (
    .offset    (al_off),
    .size      (al_size),
    .phase     (al_phase),
    .wdata     (al_wdata_in),
    .mem_be    (al_be),
    .mem_wdata (al_wdata)
  );

  assign split = ({2'b00, addr_q[1:0]} + {1'b0, size_of(f3_q)}) > 4'd4;
  assign addr1 = {addr_q[XLEN-1:2], 2'b00} + XLEN'(4);

  // Hold the pipe while an access is outstanding, including the cycle it is first presented.
  assign stall = ((state != S_IDLE) && (state != S_DONE)) || ((state == S_IDLE) && req_valid);

  // Access sequencer with registered bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      addr_q        <= '0;
      wdata_q       <= '0;
      lo_q          <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (!f3_legal(req_we, req_funct3)) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state         <= S_REQ0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= req_we;
              bus.mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              bus.mem_be    <= al_be;
              bus.mem_wdata <= al_wdata;
            end
          end
        end
        S_REQ0: begin
          if (bus.mem_gnt) begin
            if (!we_q) begin
              state       <= S_WAIT0;
              bus.mem_req <= 1'b0;
            end else if (split) begin
              state         <= S_REQ1;
              bus.mem_addr  <= addr1;
              bus.mem_be    <= al_be;
              bus.mem_wdata <= al_wdata;
            end else begin
              state       <= S_DONE;
              bus.mem_req <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b0;
            end
          end
        end
        S_WAIT0: begin
          if (bus.mem_rvalid) begin
            lo_q <= bus.mem_rdata;
            if (split) begin
              state         <= S_REQ1;
              bus.mem_req   <= 1'b1;
              bus.mem_addr  <= addr1;
              bus.mem_be    <= al_be;
              bus.mem_wdata <= al_wdata;
            end else begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= load_extend(f3_q, load_merge('0, bus.mem_rdata, addr_q[1:0]));
            end
          end
        end
        S_REQ1: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (we_q) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
            end else begin
              state <= S_WAIT1;
            end
          end
        end
        S_WAIT1: begin
          if (bus.mem_rvalid) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_extend(f3_q, load_merge(bus.mem_rdata, lo_q, addr_q[1:0]));
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          bus.mem_req <= 1'b0;
          rsp_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed vector bench for lsu_mem_port with a cycle-stepped memory responder.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] lo;
    logic [31:0] hi;
    int          gdly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_n;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    int          exp_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[13];

  lsu_mem_port_if mif ();

  lsu_mem_port dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus        (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one access at a negedge, act as memory, and compare the bus trace and response.
  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          nacc;
    int          wait_cnt;
    int          stall_cnt;
    int          rsp_cyc;
    logic        pend;
    logic        done;
    logic        got_err;
    logic [31:0] got_rdata;
    logic [31:0] acc_a  [2];
    logic [3:0]  acc_be [2];
    logic [31:0] acc_wd [2];
    logic        acc_we [2];
    logic [31:0] prev_a;
    logic [3:0]  prev_be;
    cyc = 0; nacc = 0; wait_cnt = 0; stall_cnt = 0; rsp_cyc = -1;
    pend = 1'b0; done = 1'b0; got_err = 1'b0; got_rdata = '0;
    prev_a = '0; prev_be = '0;
    for (int k = 0; k < 2; k++) begin
      acc_a[k] = '0; acc_be[k] = '0; acc_wd[k] = '0; acc_we[k] = 1'b0;
    end
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    while (!done && cyc < 60) begin
      mif.mem_gnt = 1'b0;
      mif.mem_rvalid = 1'b0;
      if (rsp_valid) begin
        done = 1'b1;
        rsp_cyc = cyc;
        got_rdata = rsp_rdata;
        got_err = rsp_err;
        req_valid = 1'b0;
      end else begin
        if (pend) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata = (nacc == 1) ? v.lo : v.hi;
          pend = 1'b0;
        end
        if (mif.mem_req) begin
          if (wait_cnt > 0) begin
            chk({tag, "_hold_addr"}, mif.mem_addr, prev_a);
            chk({tag, "_hold_be"}, 32'(mif.mem_be), 32'(prev_be));
          end
          prev_a = mif.mem_addr;
          prev_be = mif.mem_be;
          if (wait_cnt >= v.gdly) begin
            mif.mem_gnt = 1'b1;
            if (nacc < 2) begin
              acc_a[nacc] = mif.mem_addr;
              acc_be[nacc] = mif.mem_be;
              acc_wd[nacc] = mif.mem_wdata;
              acc_we[nacc] = mif.mem_we;
            end
            nacc++;
            wait_cnt = 0;
            if (!mif.mem_we) pend = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
      end
      #1;
      if (stall) stall_cnt++;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(v.exp_cyc));
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(v.exp_cyc));
    chk({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
    if (!v.exp_err) chk({tag, "_rdata"}, got_rdata, v.exp_rdata);
    chk({tag, "_n_access"}, 32'(nacc), 32'(v.exp_n));
    if (v.exp_n >= 1) begin
      chk({tag, "_addr0"}, acc_a[0], v.a0);
      chk({tag, "_be0"}, 32'(acc_be[0]), 32'(v.be0));
      chk({tag, "_wdata0"}, acc_wd[0], v.wd0);
      chk({tag, "_we0"}, 32'(acc_we[0]), 32'(v.we));
    end
    if (v.exp_n >= 2) begin
      chk({tag, "_addr1"}, acc_a[1], v.a1);
      chk({tag, "_be1"}, 32'(acc_be[1]), 32'(v.be1));
      chk({tag, "_wdata1"}, acc_wd[1], v.wd1);
    end
    @(negedge clk);
    #1;
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    //            we    f3      addr          wdata         lo            hi            gd exp_rdata     err n  a0            be0      wd0           a1            be1      wd1           cyc
    vecs[0]  = '{1'b0, F3_LW,  32'h00000100, 32'h00000000, 32'h8899AABB, 32'h00000000, 0, 32'h8899AABB, 0, 1, 32'h00000100, 4'b1111, 32'h00000000, 32'h0,        4'b0000, 32'h0,        3};
    vecs[1]  = '{1'b0, F3_LB,  32'h00000103, 32'h00000000, 32'h80FFEE11, 32'h00000000, 0, 32'hFFFFFF80, 0, 1, 32'h00000100, 4'b1000, 32'h00000000, 32'h0,        4'b0000, 32'h0,        3};
    vecs[2]  = '{1'b0, F3_LBU, 32'h00000103, 32'h00000000, 32'h80FFEE11, 32'h00000000, 0, 32'h00000080, 0, 1, 32'h00000100, 4'b1000, 32'h00000000, 32'h0,        4'b0000, 32'h0,        3};
    vecs[3]  = '{1'b1, F3_LH,  32'h00000202, 32'h1234ABCD, 32'h00000000, 32'h00000000, 0, 32'h00000080, 0, 1, 32'h00000200, 4'b1100, 32'hABCD0000, 32'h0,        4'b0000, 32'h0,        2};
    vecs[4]  = '{1'b1, F3_LW,  32'h000003FE, 32'hDDCCBBAA, 32'h00000000, 32'h00000000, 0, 32'h00000080, 0, 2, 32'h000003FC, 4'b1100, 32'hBBAA0000, 32'h00000400, 4'b0011, 32'h0000DDCC, 3};
    vecs[5]  = '{1'b0, F3_LHU, 32'h000000FF, 32'h00000000, 32'h11334455, 32'h66778822, 2, 32'h00002211, 0, 2, 32'h000000FC, 4'b1000, 32'h00000000, 32'h00000100, 4'b0001, 32'h00000000, 9};
    vecs[6]  = '{1'b0, 3'b011, 32'h00000100, 32'h00000000, 32'h00000000, 32'h00000000, 0, 32'h00000000, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1};
    vecs[7]  = '{1'b0, F3_LH,  32'h00000002, 32'h00000000, 32'h80017777, 32'h00000000, 0, 32'hFFFF8001, 0, 1, 32'h00000000, 4'b1100, 32'h00000000, 32'h0,        4'b0000, 32'h0,        3};
    vecs[8]  = '{1'b0, F3_LW,  32'h00000001, 32'h00000000, 32'hAABBCCDD, 32'h11223344, 0, 32'h44AABBCC, 0, 2, 32'h00000000, 4'b1110, 32'h00000000, 32'h00000004, 4'b0001, 32'h00000000, 5};
    vecs[9]  = '{1'b1, F3_LW,  32'hFFFFFFFD, 32'h01020304, 32'h00000000, 32'h00000000, 0, 32'h44AABBCC, 0, 2, 32'hFFFFFFFC, 4'b1110, 32'h02030400, 32'h00000000, 4'b0001, 32'h00000001, 3};
    vecs[10] = '{1'b1, F3_LB,  32'h00000005, 32'hFFFFFF5A, 32'h00000000, 32'h00000000, 0, 32'h44AABBCC, 0, 1, 32'h00000004, 4'b0010, 32'hFFFF5A00, 32'h0,        4'b0000, 32'h0,        2};
    vecs[11] = '{1'b1, F3_LBU, 32'h00000008, 32'h000000FF, 32'h00000000, 32'h00000000, 0, 32'h00000000, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1};
    vecs[12] = '{1'b0, F3_LHU, 32'h00000006, 32'h00000000, 32'hBEEF1234, 32'h00000000, 1, 32'h0000BEEF, 0, 1, 32'h00000004, 4'b1100, 32'h00000000, 32'h0,        4'b0000, 32'h0,        4};

    mif.mem_gnt = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mif.mem_be), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a request waits for grant drops mem_req at once
    req_we = 1'b1; req_funct3 = F3_LW; req_addr = 32'h00000010; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rq0_mem_req_before", 32'(mif.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rq0_mem_req_after_rst", 32'(mif.mem_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during WAIT0 aborts the load; a late rvalid must be ignored
    req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h00000100; req_wdata = '0;
    req_valid = 1'b1;
    @(negedge clk);
    mif.mem_gnt = 1'b1;
    @(negedge clk);
    mif.mem_gnt = 1'b0;
    #1;
    chk("w0_stall_before", 32'(stall), 32'd1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("w0_mem_req", 32'(mif.mem_req), 32'd0);
    chk("w0_stall_idle", 32'(stall), 32'd0);
    chk("w0_mem_addr", mif.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata = 32'h5555AAAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mif.mem_rvalid = 1'b0;
      chk($sformatf("w0_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("w0_no_req%0d", k), 32'(mif.mem_req), 32'd0);
    end
    chk("w0_rdata_cleared", rsp_rdata, 32'd0);

    // Normal operation resumes after the abort
    run_vec(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
